// File: rtl/pipe_pkg.sv
// pipe_pkg: shared MDU latency defaults, Tuse encoding and control FSM states.
package pipe_pkg;
  localparam int MULT_CYC_DEF = 5;
  localparam int DIV_CYC_DEF = 10;
  localparam logic [1:0] TUSE_NONE = 2'd3;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} mdu_state_e;
endpackage

// File: rtl/hazard_cmp.sv
// hazard_cmp: stalls one D-stage source operand that E or M cannot yet forward in time.
module hazard_cmp
  import pipe_pkg::*;
(
  input  logic [4:0] a_i,
  input  logic [1:0] tuse_i,
  input  logic [4:0] a3_e_i,
  input  logic [1:0] tnew_e_i,
  input  logic [4:0] a3_m_i,
  input  logic [1:0] tnew_m_i,
  output logic       stall_o
);
  logic hit_e, hit_m;
  assign hit_e = (a_i == a3_e_i) && (tnew_e_i > tuse_i);
  assign hit_m = (a_i == a3_m_i) && (tnew_m_i > tuse_i);
  assign stall_o = (a_i != 5'd0) && (tuse_i != TUSE_NONE) && (hit_e || hit_m);
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush control with MDU busy tracking.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] A1_D,
  input  logic [4:0] A2_D,
  input  logic [1:0] Tuse_rs_D,
  input  logic [1:0] Tuse_rt_D,
  input  logic [4:0] A3_E,
  input  logic [4:0] A3_M,
  input  logic [1:0] Tnew_E,
  input  logic [1:0] Tnew_M,
  input  logic       md_D,
  input  logic       start_E,
  input  logic       div_E,
  input  logic       eret_D,
  input  logic       epc_wr_E,
  input  logic       epc_wr_M,
  input  logic       Req,
  output logic       en_PC,
  output logic       en_FD,
  output logic       clr_DE,
  output logic       busy
);
  if (MULT_CYC < 1 || MULT_CYC > 15 || DIV_CYC < 1 || DIV_CYC > 15) begin : g_bad_param
    $error("pipe_ctrl: MULT_CYC and DIV_CYC must be in 1..15");
  end
  mdu_state_e state_q;
  logic [3:0] cnt_q;
  logic       busy_q;
  logic       stall_rs, stall_rt, stall_md, stall_eret, stall;
  hazard_cmp u_rs (
    .a_i(A1_D), .tuse_i(Tuse_rs_D), .a3_e_i(A3_E), .tnew_e_i(Tnew_E),
    .a3_m_i(A3_M), .tnew_m_i(Tnew_M), .stall_o(stall_rs)
  );
  hazard_cmp u_rt (
    .a_i(A2_D), .tuse_i(Tuse_rt_D), .a3_e_i(A3_E), .tnew_e_i(Tnew_E),
    .a3_m_i(A3_M), .tnew_m_i(Tnew_M), .stall_o(stall_rt)
  );
  assign stall_md   = md_D && (busy_q || start_E);
  assign stall_eret = eret_D && (epc_wr_E || epc_wr_M);
  assign stall      = stall_rs || stall_rt || stall_md || stall_eret;
  // An exception request flushes the pipeline itself, so it overrides any stall.
  assign en_PC  = Req || !stall;
  assign en_FD  = Req || !stall;
  assign clr_DE = !Req && stall;
  assign busy   = busy_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
    end else if (start_E && !Req) begin
      state_q <= BUSY;
      cnt_q   <= div_E ? 4'(DIV_CYC) : 4'(MULT_CYC);
      busy_q  <= 1'b1;
    end else if (state_q == BUSY) begin
      state_q <= (cnt_q == 4'd1) ? IDLE : BUSY;
      cnt_q   <= cnt_q - 4'd1;
      busy_q  <= cnt_q != 4'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset && start_E) assert (state_q != BUSY) else $error("pipe_ctrl: MDU start while busy");
  end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed checks of stall, Req override and MDU busy timing.
module tb_pipe_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] A1_D, A2_D, A3_E, A3_M;
  logic [1:0] Tuse_rs_D, Tuse_rt_D, Tnew_E, Tnew_M;
  logic       md_D, start_E, div_E, eret_D, epc_wr_E, epc_wr_M, Req;
  logic       en_PC, en_FD, clr_DE, busy;
  int checks = 0;
  int failures = 0;
  localparam logic [2:0] RUN = 3'b110;
  localparam logic [2:0] STL = 3'b001;
  pipe_ctrl dut (
    .clk(clk), .reset(reset), .A1_D(A1_D), .A2_D(A2_D), .Tuse_rs_D(Tuse_rs_D),
    .Tuse_rt_D(Tuse_rt_D), .A3_E(A3_E), .A3_M(A3_M), .Tnew_E(Tnew_E), .Tnew_M(Tnew_M),
    .md_D(md_D), .start_E(start_E), .div_E(div_E), .eret_D(eret_D), .epc_wr_E(epc_wr_E),
    .epc_wr_M(epc_wr_M), .Req(Req), .en_PC(en_PC), .en_FD(en_FD), .clr_DE(clr_DE), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [2:0] exp_o, input logic exp_b);
    checks++;
    assert ({en_PC, en_FD, clr_DE, busy} === {exp_o, exp_b})
    else begin
      failures++;
      $error("FAIL %s obs(en_PC,en_FD,clr_DE,busy)=%b exp=%b", tag, {en_PC, en_FD, clr_DE, busy}, {exp_o, exp_b});
    end
  endtask
  task automatic cyc();
    @(negedge clk);
  endtask
  initial begin
    reset = 1'b0;
    {A1_D, A2_D, A3_E, A3_M} = '0;
    {Tuse_rs_D, Tuse_rt_D, Tnew_E, Tnew_M} = '0;
    {md_D, start_E, div_E, eret_D, epc_wr_E, epc_wr_M, Req} = '0;
    #3 chk("reset", RUN, 1'b0);
    cyc();
    reset = 1'b1;
    #1 chk("after_reset", RUN, 1'b0);
    // load-use: lw $1 in E, rs=$1 needed now
    cyc();
    A1_D = 5'd1; Tuse_rs_D = 2'd0; A3_E = 5'd1; Tnew_E = 2'd2;
    #1 chk("lw_use_e", STL, 1'b0);
    cyc();
    A3_E = 5'd0; Tnew_E = 2'd0; A3_M = 5'd1; Tnew_M = 2'd1;
    #1 chk("lw_use_m", STL, 1'b0);
    cyc();
    A3_M = 5'd0; Tnew_M = 2'd0;
    #1 chk("lw_use_release", RUN, 1'b0);
    cyc();
    A1_D = 5'd0; A2_D = 5'd7; Tuse_rt_D = 2'd2; A3_E = 5'd7; Tnew_E = 2'd2;
    #1 chk("rt_tnew_eq_tuse", RUN, 1'b0);
    Tuse_rt_D = 2'd1;
    #1 chk("rt_tnew_gt_tuse", STL, 1'b0);
    Tuse_rt_D = 2'd3; Tnew_E = 2'd3;
    #1 chk("rt_not_used", RUN, 1'b0);
    Tuse_rt_D = 2'd0; A3_E = 5'd0; A3_M = 5'd7; Tnew_M = 2'd1;
    #1 chk("rt_hit_m", STL, 1'b0);
    Req = 1'b1;
    #1 chk("req_overrides_stall", RUN, 1'b0);
    Req = 1'b0; A2_D = 5'd0; A3_M = 5'd0; Tnew_M = 2'd0; Tnew_E = 2'd3;
    #1 chk("zero_reg_no_stall", RUN, 1'b0);
    Tnew_E = 2'd0;
    // mult then mflo waiting in D
    cyc();
    start_E = 1'b1; div_E = 1'b0;
    #1 chk("mult_start", RUN, 1'b0);
    cyc();
    start_E = 1'b0; md_D = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1 chk($sformatf("mult_busy_%0d", i), STL, 1'b1);
      cyc();
    end
    #1 chk("mult_done", RUN, 1'b0);
    // div with mfhi in D; Req in third busy cycle
    start_E = 1'b1; div_E = 1'b1;
    #1 chk("div_start_md_stall", STL, 1'b0);
    cyc();
    start_E = 1'b0; div_E = 1'b0;
    for (int i = 0; i < 10; i++) begin
      Req = (i == 2);
      #1 chk($sformatf("div_busy_%0d", i), (i == 2) ? RUN : STL, 1'b1);
      cyc();
    end
    Req = 1'b0;
    #1 chk("div_done", RUN, 1'b0);
    md_D = 1'b0;
    // start coinciding with Req is ignored
    cyc();
    start_E = 1'b1; Req = 1'b1;
    #1 chk("start_with_req", RUN, 1'b0);
    cyc();
    start_E = 1'b0; Req = 1'b0;
    #1 chk("start_with_req_ignored", RUN, 1'b0);
    // eret behind mtc0 EPC
    cyc();
    eret_D = 1'b1; epc_wr_E = 1'b1;
    #1 chk("eret_epc_e", STL, 1'b0);
    cyc();
    epc_wr_E = 1'b0; epc_wr_M = 1'b1;
    #1 chk("eret_epc_m", STL, 1'b0);
    cyc();
    epc_wr_M = 1'b0;
    #1 chk("eret_release", RUN, 1'b0);
    eret_D = 1'b0;
    // asynchronous reset while dividing, at cnt=6
    cyc();
    start_E = 1'b1; div_E = 1'b1;
    cyc();
    start_E = 1'b0; div_E = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    #1 chk("div_before_reset", RUN, 1'b1);
    reset = 1'b0;
    #1 chk("async_reset_abort", RUN, 1'b0);
    cyc();
    reset = 1'b1;
    cyc();
    #1 chk("after_abort", RUN, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
